// File: rtl/sdhci_pkg.sv
// Shared types and constants for the SDHCI command arbiter.
package sdhci_pkg;

  localparam int unsigned CMD_IDX_W    = 6;
  localparam int unsigned CMD_ARG_W    = 32;
  localparam int unsigned RESP_TYPE_W  = 2;
  localparam int unsigned DRV_ERR_W    = 4;
  localparam int unsigned ACMD12_ERR_W = 8;

  // Command as presented to the command-line transmitter
  typedef struct packed {
    logic [CMD_IDX_W-1:0]   index;
    logic [CMD_ARG_W-1:0]   arg;
    logic [RESP_TYPE_W-1:0] resp_type;
    logic                   crc_chk;
    logic                   idx_chk;
  } cmd_t;

  // Response error flags, valid with rsp_done
  typedef struct packed {
    logic timeout;
    logic crc;
    logic end_bit;
    logic index;
  } rsp_err_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_ACM,
    WAIT_ACM,
    ISSUE_DRV,
    WAIT_DRV
  } arb_state_e;

  // Auto CMD12 Error Status bit positions
  localparam int unsigned ACMD12_ERR_NOT_EXEC   = 0;
  localparam int unsigned ACMD12_ERR_TIMEOUT    = 1;
  localparam int unsigned ACMD12_ERR_CRC        = 2;
  localparam int unsigned ACMD12_ERR_END_BIT    = 3;
  localparam int unsigned ACMD12_ERR_INDEX      = 4;
  localparam int unsigned ACMD12_ERR_NOT_ISSUED = 7;

  // Error Interrupt Status [3:0] bit positions
  localparam int unsigned ERR_INT_TIMEOUT = 0;
  localparam int unsigned ERR_INT_CRC     = 1;
  localparam int unsigned ERR_INT_END_BIT = 2;
  localparam int unsigned ERR_INT_INDEX   = 3;

  // Map response errors onto Error Interrupt Status bits
  function automatic logic [DRV_ERR_W-1:0] map_drv_err(input rsp_err_t e);
    logic [DRV_ERR_W-1:0] r;
    r                  = '0;
    r[ERR_INT_TIMEOUT] = e.timeout;
    r[ERR_INT_CRC]     = e.crc;
    r[ERR_INT_END_BIT] = e.end_bit;
    r[ERR_INT_INDEX]   = e.index;
    return r;
  endfunction

  // Map response errors onto Auto CMD12 Error Status bits
  function automatic logic [ACMD12_ERR_W-1:0] map_acm_err(input rsp_err_t e);
    logic [ACMD12_ERR_W-1:0] r;
    r                     = '0;
    r[ACMD12_ERR_TIMEOUT] = e.timeout;
    r[ACMD12_ERR_CRC]     = e.crc;
    r[ACMD12_ERR_END_BIT] = e.end_bit;
    r[ACMD12_ERR_INDEX]   = e.index;
    return r;
  endfunction

endpackage

// File: rtl/sdhci_cmd_arbiter.sv
// Arbitrates driver commands against Auto CMD12 and routes response errors.
// Optional: define SDHCI_ACMD12_RETRY_EN to retry one crc/end-bit-only
// Auto CMD12 failure before reporting it.
module sdhci_cmd_arbiter
  import sdhci_pkg::*;
#(
  parameter logic [CMD_IDX_W-1:0]   Acmd12Index    = 6'd12,
  parameter logic [RESP_TYPE_W-1:0] Acmd12RespType = 2'b11
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    drv_req_i,
  input  cmd_t                    drv_cmd_i,
  input  logic                    acmd12_req_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output cmd_t                    cmd_o,
  input  logic                    rsp_done_i,
  input  rsp_err_t                rsp_err_i,
  output logic                    cmd_inhibit_o,
  output logic                    drv_done_o,
  output logic [DRV_ERR_W-1:0]    drv_err_o,
  output logic                    acmd12_done_o,
  output logic [ACMD12_ERR_W-1:0] acmd12_err_o,
  output logic                    acmd12_err_int_o
);

  arb_state_e              state_q, state_d;
  logic                    drv_pend_q, drv_pend_d;
  logic                    acm_pend_q, acm_pend_d;
  cmd_t                    drv_cmd_q, drv_cmd_d;
  cmd_t                    cmd_d;
  logic                    cmd_valid_d;
  logic                    inhibit_d;
  logic                    drv_done_d;
  logic [DRV_ERR_W-1:0]    drv_err_d;
  logic                    acm_done_d;
  logic [ACMD12_ERR_W-1:0] acm_err_d;
  logic                    rsp_any_err;
  logic                    acm_retry;
  cmd_t                    acm_cmd;
`ifdef SDHCI_ACMD12_RETRY_EN
  logic                    retry_q, retry_d;
`endif

  assign rsp_any_err = rsp_err_i.timeout | rsp_err_i.crc | rsp_err_i.end_bit | rsp_err_i.index;

  // Fixed Auto CMD12 command word
  always_comb begin
    acm_cmd           = '0;
    acm_cmd.index     = Acmd12Index;
    acm_cmd.arg       = '0;
    acm_cmd.resp_type = Acmd12RespType;
    acm_cmd.crc_chk   = 1'b1;
    acm_cmd.idx_chk   = 1'b1;
  end

  // A crc/end-bit-only Auto CMD12 failure may be retried once
  always_comb begin
`ifdef SDHCI_ACMD12_RETRY_EN
    acm_retry = !retry_q && !rsp_err_i.timeout && !rsp_err_i.index &&
                (rsp_err_i.crc || rsp_err_i.end_bit);
`else
    acm_retry = 1'b0;
`endif
  end

  // Next state, request latching and response routing
  always_comb begin
    state_d     = state_q;
    drv_pend_d  = drv_pend_q;
    acm_pend_d  = acm_pend_q;
    drv_cmd_d   = drv_cmd_q;
    cmd_d       = cmd_o;
    drv_done_d  = 1'b0;
    drv_err_d   = '0;
    acm_done_d  = 1'b0;
    acm_err_d   = '0;
`ifdef SDHCI_ACMD12_RETRY_EN
    retry_d     = retry_q;
`endif

    if (drv_req_i && !drv_pend_q) begin
      drv_pend_d = 1'b1;
      drv_cmd_d  = drv_cmd_i;
    end
    if (acmd12_req_i && !acm_pend_q) begin
      acm_pend_d = 1'b1;
`ifdef SDHCI_ACMD12_RETRY_EN
      retry_d    = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (acm_pend_q) begin
          state_d = ISSUE_ACM;
          cmd_d   = acm_cmd;
        end else if (drv_pend_q) begin
          state_d = ISSUE_DRV;
          cmd_d   = drv_cmd_q;
        end
      end
      ISSUE_ACM: begin
        if (cmd_ready_i) begin
          if (acm_pend_q) acm_pend_d = 1'b0;
          state_d = WAIT_ACM;
        end
      end
      WAIT_ACM: begin
        if (rsp_done_i) begin
          if (!rsp_any_err) begin
            acm_done_d = 1'b1;
            state_d    = IDLE;
          end else if (acm_retry) begin
`ifdef SDHCI_ACMD12_RETRY_EN
            retry_d    = 1'b1;
`endif
            state_d    = ISSUE_ACM;
          end else begin
            acm_err_d = map_acm_err(rsp_err_i);
            if (drv_pend_q) begin
              acm_err_d[ACMD12_ERR_NOT_ISSUED] = 1'b1;
              drv_pend_d                       = 1'b0;
            end
            state_d = IDLE;
          end
        end
      end
      ISSUE_DRV: begin
        if (cmd_ready_i) begin
          drv_pend_d = 1'b0;
          state_d    = WAIT_DRV;
        end
      end
      WAIT_DRV: begin
        if (rsp_done_i) begin
          if (!rsp_any_err) begin
            drv_done_d = 1'b1;
          end else begin
            drv_err_d = map_drv_err(rsp_err_i);
            if (acm_pend_q) begin
              acm_err_d[ACMD12_ERR_NOT_EXEC] = 1'b1;
              acm_pend_d                     = 1'b0;
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d = (state_d == ISSUE_ACM) || (state_d == ISSUE_DRV);
    inhibit_d   = drv_pend_d || (state_d == ISSUE_DRV) || (state_d == WAIT_DRV);
  end

  // State, pending flags and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      drv_pend_q       <= 1'b0;
      acm_pend_q       <= 1'b0;
      drv_cmd_q        <= '0;
      cmd_o            <= '0;
      cmd_valid_o      <= 1'b0;
      cmd_inhibit_o    <= 1'b0;
      drv_done_o       <= 1'b0;
      drv_err_o        <= '0;
      acmd12_done_o    <= 1'b0;
      acmd12_err_o     <= '0;
      acmd12_err_int_o <= 1'b0;
`ifdef SDHCI_ACMD12_RETRY_EN
      retry_q          <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      drv_pend_q       <= drv_pend_d;
      acm_pend_q       <= acm_pend_d;
      drv_cmd_q        <= drv_cmd_d;
      cmd_o            <= cmd_d;
      cmd_valid_o      <= cmd_valid_d;
      cmd_inhibit_o    <= inhibit_d;
      drv_done_o       <= drv_done_d;
      drv_err_o        <= drv_err_d;
      acmd12_done_o    <= acm_done_d;
      acmd12_err_o     <= acm_err_d;
      acmd12_err_int_o <= |acm_err_d;
`ifdef SDHCI_ACMD12_RETRY_EN
      retry_q          <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_arbiter.sv
// Scoreboard bench for sdhci_cmd_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sdhci_cmd_arbiter;
  import sdhci_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        drv_req_i;
  cmd_t        drv_cmd_i;
  logic        acmd12_req_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  cmd_t        cmd_o;
  logic        rsp_done_i;
  rsp_err_t    rsp_err_i;
  logic        cmd_inhibit_o;
  logic        drv_done_o;
  logic [3:0]  drv_err_o;
  logic        acmd12_done_o;
  logic [7:0]  acmd12_err_o;
  logic        acmd12_err_int_o;

  always #5 clk_i = ~clk_i;

  sdhci_cmd_arbiter dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .drv_req_i        (drv_req_i),
    .drv_cmd_i        (drv_cmd_i),
    .acmd12_req_i     (acmd12_req_i),
    .cmd_valid_o      (cmd_valid_o),
    .cmd_ready_i      (cmd_ready_i),
    .cmd_o            (cmd_o),
    .rsp_done_i       (rsp_done_i),
    .rsp_err_i        (rsp_err_i),
    .cmd_inhibit_o    (cmd_inhibit_o),
    .drv_done_o       (drv_done_o),
    .drv_err_o        (drv_err_o),
    .acmd12_done_o    (acmd12_done_o),
    .acmd12_err_o     (acmd12_err_o),
    .acmd12_err_int_o (acmd12_err_int_o)
  );

  localparam int EV_CMD      = 0;
  localparam int EV_DRV_DONE = 1;
  localparam int EV_DRV_ERR  = 2;
  localparam int EV_ACM_DONE = 3;
  localparam int EV_ACM_ERR  = 4;

  typedef struct {
    int          kind;
    logic [47:0] data;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  cmd_t acm_cmd;
  cmd_t drv_a;
  cmd_t drv_b;

  function automatic string ev_name(input int k);
    case (k)
      EV_CMD:      return "cmd";
      EV_DRV_DONE: return "drv_done";
      EV_DRV_ERR:  return "drv_err";
      EV_ACM_DONE: return "acm_done";
      EV_ACM_ERR:  return "acm_err";
      default:     return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [47:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [47:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %h expected no event (t=%0t)", ev_name(kind), data, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        n_fail++;
        $display("FAIL event_order: got %s %h expected %s %h (t=%0t)",
                 ev_name(kind), data, ev_name(e.kind), e.data, $time);
      end
    end
  endtask

  // Monitor: every handshake and pulse must match the next expected event
  always @(negedge clk_i) begin
    if (cmd_valid_o && cmd_ready_i) observe(EV_CMD, {6'd0, cmd_o});
    if (drv_done_o)                 observe(EV_DRV_DONE, 48'd0);
    if (|drv_err_o)                 observe(EV_DRV_ERR, {44'd0, drv_err_o});
    if (acmd12_done_o)              observe(EV_ACM_DONE, 48'd0);
    if (|acmd12_err_o)              observe(EV_ACM_ERR, {40'd0, acmd12_err_o});
    if (acmd12_err_int_o || (|acmd12_err_o))
      check("acm_err_int", {47'd0, acmd12_err_int_o}, {47'd0, |acmd12_err_o});
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Wait for cmd_valid_o, then accept it for one cycle
  task automatic handshake();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_valid_o) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("issue_seen", {47'd0, seen}, 48'd1);
    if (seen) begin
      cmd_ready_i = 1'b1;
      tick();
      cmd_ready_i = 1'b0;
    end
  endtask

  task automatic respond(input rsp_err_t err, input int delay);
    repeat (delay) tick();
    rsp_done_i = 1'b1;
    rsp_err_i  = err;
    tick();
    rsp_done_i = 1'b0;
    rsp_err_i  = '0;
    repeat (3) tick();
  endtask

  task automatic no_issue(input string name, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (cmd_valid_o) cnt++;
      tick();
    end
    check(name, 48'(cnt), 48'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"},   {47'd0, cmd_valid_o}, 48'd0);
    check({name, "_cmd"},     {6'd0, cmd_o}, 48'd0);
    check({name, "_inhibit"}, {47'd0, cmd_inhibit_o}, 48'd0);
    check({name, "_pulses"},
          {32'd0, drv_done_o, drv_err_o, acmd12_done_o, acmd12_err_o, acmd12_err_int_o},
          48'd0);
  endtask

  rsp_err_t clean;
  rsp_err_t crc_idx;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    acm_cmd   = '{index: 6'd12, arg: 32'd0, resp_type: 2'b11, crc_chk: 1'b1, idx_chk: 1'b1};
    drv_a     = '{index: 6'd0, arg: 32'h0000_1234, resp_type: 2'b01, crc_chk: 1'b1, idx_chk: 1'b0};
    drv_b     = '{index: 6'd17, arg: 32'hdead_beef, resp_type: 2'b10, crc_chk: 1'b0, idx_chk: 1'b1};
    clean     = '0;
    crc_idx   = '{timeout: 1'b0, crc: 1'b1, end_bit: 1'b0, index: 1'b1};

    rst_ni       = 1'b0;
    drv_req_i    = 1'b0;
    drv_cmd_i    = '0;
    acmd12_req_i = 1'b0;
    cmd_ready_i  = 1'b0;
    rsp_done_i   = 1'b0;
    rsp_err_i    = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    // Same-cycle requests, both clean: Auto CMD12 wins
    push(EV_CMD, {6'd0, acm_cmd});
    push(EV_ACM_DONE, 48'd0);
    push(EV_CMD, {6'd0, drv_a});
    push(EV_DRV_DONE, 48'd0);
    drv_req_i = 1'b1; drv_cmd_i = drv_a; acmd12_req_i = 1'b1;
    tick();
    drv_req_i = 1'b0; acmd12_req_i = 1'b0; drv_cmd_i = '0;
    check("inhibit_after_req", {47'd0, cmd_inhibit_o}, 48'd1);
    handshake();
    respond(clean, 2);
    handshake();
    respond(clean, 2);
    check("inhibit_idle", {47'd0, cmd_inhibit_o}, 48'd0);

    // Driver three cycles before Auto CMD12, both clean
    push(EV_CMD, {6'd0, drv_a});
    push(EV_DRV_DONE, 48'd0);
    push(EV_CMD, {6'd0, acm_cmd});
    push(EV_ACM_DONE, 48'd0);
    drv_req_i = 1'b1; drv_cmd_i = drv_a;
    tick();
    drv_req_i = 1'b0; drv_cmd_i = '0;
    repeat (2) tick();
    acmd12_req_i = 1'b1;
    tick();
    acmd12_req_i = 1'b0;
    handshake();
    respond(clean, 3);
    handshake();
    respond(clean, 3);

    // Same-cycle requests, Auto CMD12 fails: driver command dropped
    push(EV_CMD, {6'd0, acm_cmd});
    push(EV_ACM_ERR, 48'h94);
    drv_req_i = 1'b1; drv_cmd_i = drv_b; acmd12_req_i = 1'b1;
    tick();
    drv_req_i = 1'b0; acmd12_req_i = 1'b0; drv_cmd_i = '0;
    handshake();
    respond(crc_idx, 2);
    no_issue("drv_suppressed", 80);
    check("inhibit_after_suppress", {47'd0, cmd_inhibit_o}, 48'd0);

    // Driver first, driver fails: Auto CMD12 not executed
    push(EV_CMD, {6'd0, drv_b});
    push(EV_DRV_ERR, 48'ha);
    push(EV_ACM_ERR, 48'h01);
    drv_req_i = 1'b1; drv_cmd_i = drv_b;
    tick();
    drv_req_i = 1'b0; drv_cmd_i = '0;
    repeat (2) tick();
    acmd12_req_i = 1'b1;
    tick();
    acmd12_req_i = 1'b0;
    handshake();
    respond(crc_idx, 2);
    no_issue("acm_suppressed", 80);

    // Transmitter stalls: command held stable
    push(EV_CMD, {6'd0, drv_b});
    push(EV_DRV_DONE, 48'd0);
    drv_req_i = 1'b1; drv_cmd_i = drv_b;
    tick();
    drv_req_i = 1'b0; drv_cmd_i = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",   {47'd0, cmd_valid_o}, 48'd1);
      check("stall_cmd",     {6'd0, cmd_o}, {6'd0, drv_b});
      check("stall_inhibit", {47'd0, cmd_inhibit_o}, 48'd1);
      tick();
    end
    handshake();
    respond(clean, 2);

    // Reset during WAIT_DRV abandons the command silently
    push(EV_CMD, {6'd0, drv_a});
    drv_req_i = 1'b1; drv_cmd_i = drv_a;
    tick();
    drv_req_i = 1'b0; drv_cmd_i = '0;
    handshake();
    tick();
    check("wait_drv_inhibit", {47'd0, cmd_inhibit_o}, 48'd1);
    rst_ni = 1'b0;
    tick();
    check_all_zero("midreset");
    rst_ni = 1'b1;
    repeat (2) tick();
    respond(crc_idx, 0);
    no_issue("post_reset_idle", 10);
    check("post_reset_inhibit", {47'd0, cmd_inhibit_o}, 48'd0);

    repeat (5) tick();
    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdhci_cmd_arbiter.md
Name: sdhci_cmd_arbiter

Overview:
Sits directly upstream of the command-line transmitter/receiver. Arbitrates between host-driver commands (Command register write) and the Auto CMD12 request raised by the data path after the last block. Issues one command at a time and routes each response's error flags to the Normal/Error status path or the Auto CMD12 Error Status path. Implements the issue/suppress rules that the Auto CMD12 integration bench exercises.

Parameters:
- Acmd12Index, 6'd12, command index used for Auto CMD12
- Acmd12RespType, 2'b11, response type for Auto CMD12 (48-bit with busy, R1b)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i
- drv_req_i  in  1  pulse: driver wrote the Command register
- drv_cmd_i  in  sdhci_pkg::cmd_t  index[5:0], arg[31:0], resp_type[1:0], crc_chk, idx_chk
- acmd12_req_i  in  1  pulse: last block finished and auto_cmd12_enable is set
- cmd_valid_o  out  1  command valid to transmitter
- cmd_ready_i  in  1  transmitter accepts the command
- cmd_o  out  sdhci_pkg::cmd_t  command to transmitter
- rsp_done_i  in  1  pulse: response phase finished (or no response expected)
- rsp_err_i  in  sdhci_pkg::rsp_err_t  timeout, crc, end_bit, index; valid with rsp_done_i
- cmd_inhibit_o  out  1  a driver command is pending or in flight
- drv_done_o  out  1  pulse: driver command completed without error
- drv_err_o  out  4  pulse: set bits of Error Interrupt Status [3:0] (timeout, crc, end bit, index)
- acmd12_done_o  out  1  pulse: Auto CMD12 completed without error
- acmd12_err_o  out  8  pulse: set bits of Auto CMD12 Error Status
- acmd12_err_int_o  out  1  pulse: any acmd12_err_o bit is set this cycle

Behaviour:
- Reset: state IDLE; both pending flags are 0; all outputs are 0; cmd_o is '0.
- Request latch: drv_req_i sets drv_pend and captures drv_cmd_i. acmd12_req_i sets acm_pend. A request that arrives while its flag is already set is ignored.
- cmd_inhibit_o = drv_pend OR (state is ISSUE_DRV or WAIT_DRV).
- FSM states: IDLE, ISSUE_ACM, WAIT_ACM, ISSUE_DRV, WAIT_DRV.
- IDLE:
  - If acm_pend, go to ISSUE_ACM. Otherwise, if drv_pend, go to ISSUE_DRV.
  - Auto CMD12 has priority when both requests arrive in the same cycle.
  - A request arriving in cycle N is visible to arbitration in cycle N+1.
- ISSUE_x:
  - Drive cmd_valid_o=1 with cmd_o held stable until cmd_ready_i.
  - On the handshake, clear the matching pending flag and go to WAIT_x.
  - Auto CMD12 cmd_o: index=Acmd12Index, arg=0, resp_type=Acmd12RespType, crc_chk=1, idx_chk=1.
- WAIT_ACM, on rsp_done_i:
  - If no error: pulse acmd12_done_o; go to IDLE.
  - If error: pulse acmd12_err_o with bit1=timeout, bit2=crc, bit3=end_bit, bit4=index, and pulse acmd12_err_int_o.
  - If error and drv_pend: also set bit7 (command not issued by ACMD12 error), clear drv_pend, and do not issue the driver command or pulse drv_done_o. Go to IDLE.
- WAIT_DRV, on rsp_done_i:
  - If no error: pulse drv_done_o.
  - If error: pulse drv_err_o = {index, end_bit, crc, timeout}.
  - If error and acm_pend: also pulse acmd12_err_o bit0 (not executed) and acmd12_err_int_o, and clear acm_pend. Go to IDLE.
- Output timing: done/error pulses are registered, one cycle after rsp_done_i, and one cycle wide.
- Isolation: drv_err_o is never driven by Auto CMD12 errors. acmd12_err_o is never driven by driver-command errors, except bit0.
- rsp_done_i outside WAIT_x is ignored.
- Reset asserted mid-operation returns to the reset state on the next edge. The in-flight command is abandoned with no pulses.

Optional Feature:
SDHCI_ACMD12_RETRY_EN
- Defined: an Auto CMD12 response with only crc or end_bit set (no timeout or index error) re-enters ISSUE_ACM once, with no error pulse. A second failure reports normally. A 1-bit retry counter is cleared on each new acm_pend.
- Undefined: no retry; the behaviour is exactly as above.

Decomposition:
- sdhci_pkg holds:
  - cmd_t and rsp_err_t structs
  - arb_state_e enum
  - ACMD12_ERR_* bit-position constants (NOT_EXEC=0, TIMEOUT=1, CRC=2, END_BIT=3, INDEX=4, NOT_ISSUED=7)
  - ERR_INT_* constants
- No sub-module: the error mapping is small and stays inline.

Test Plan:
- acmd12_req_i and drv_req_i in the same cycle, both responses clean -> cmd_o.index is 12 first, then 0. acmd12_done_o pulses, then drv_done_o. All error outputs stay 0.
- drv_req_i 3 cycles before acmd12_req_i, both clean -> driver index 0 is issued first, Auto CMD12 second. No errors.
- Same-cycle requests; Auto CMD12 response with crc+index errors -> acmd12_err_o=8'b1001_0100. Driver command is never issued (cmd_valid_o stays 0 for 80 cycles). drv_err_o=0.
- Driver first; driver response with crc+index errors -> drv_err_o=4'b1010, acmd12_err_o=8'b0000_0001. Auto CMD12 is never issued.
- cmd_ready_i held low for 5 cycles -> cmd_valid_o and cmd_o stay stable. cmd_inhibit_o=1 throughout.
- rst_ni asserted low during WAIT_DRV -> next cycle all outputs are 0 and the state is IDLE. A later rsp_done_i produces no pulse.
